// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_modexp_ctrl
// Purpose  : Sequencing controller for RSA modular exponentiation.
//            result = base^exp mod modn, computed by left-to-right binary
//            square-and-multiply on an interleaved shift-add modular
//            multiplier (one multiplier bit per clock).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   start    in   1  operation request, sampled only in IDLE
//   base     in   W  message/ciphertext, must be < modn
//   exp      in   W  exponent
//   modn     in   W  modulus, must be >= 2
//   busy     out  1  high while squaring or multiplying
//   done     out  1  single-cycle completion pulse
//   err      out  1  operand error, valid with done, held until next start
//   result   out  W  exponentiation result, held until next start
//   mux_sel  out  1  multiplier operand select: 0 = R (square), 1 = base
// Configuration
//   RSA_MODEXP_SKIP_LEAD_EN : when defined, leading zero exponent bits are
//                             skipped (scan starts at the highest set bit).
// ============================================================================
module rsa_modexp_ctrl #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] modn,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result,
    output logic         mux_sel
);

    localparam int c_IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_IW-1:0] c_TOP_IDX = c_IW'(W - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SQR  = 2'd1;
    localparam logic [1:0] c_MUL  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    logic [W-1:0]    r_base;
    logic [W-1:0]    r_exp;
    logic [W-1:0]    r_modn;
    logic [W-1:0]    r_r;          // running exponentiation value R
    logic [W-1:0]    r_acc;        // multiplier partial product
    logic [c_IW-1:0] r_step;       // multiplier bit index j
    logic [c_IW-1:0] r_bit;        // exponent bit index i
    logic            r_err;
    logic [W-1:0]    r_result;

    logic            w_bad;        // operand error at the sampling edge
    logic            w_last;       // final step of the current multiply
    logic [c_IW-1:0] w_start_bit;
    logic            w_exp_zero;

    logic [W-1:0]    w_opnd;
    logic [W:0]      w_n;
    logic [W:0]      w_dbl;
    logic [W-1:0]    w_red1;
    logic [W:0]      w_sum;
    logic [W-1:0]    w_acc_next;

    assign w_bad      = (modn < W'(2)) || (base >= modn);
    assign w_last     = (r_step == '0);
    assign w_exp_zero = (exp == '0);

    // Starting exponent bit: either the top bit, or the highest set bit.
`ifdef RSA_MODEXP_SKIP_LEAD_EN
    always_comb begin
        w_start_bit = '0;
        for (int k = 0; k < W; k++) begin
            if (exp[k]) begin
                w_start_bit = c_IW'(k);
            end
        end
    end
`else
    assign w_start_bit = c_TOP_IDX;
`endif

    // ------------------------------------------------------------------
    // Modular multiply step: acc = 2*acc + (R[j] ? opnd : 0) mod n.
    // acc and opnd are both < n, so each conditional subtract restores
    // the < n invariant and W+1 bits cannot overflow.
    // ------------------------------------------------------------------
    always_comb begin
        w_opnd = mux_sel ? r_base : r_r;
        w_n    = {1'b0, r_modn};
        w_dbl  = {r_acc, 1'b0};
        w_red1 = (w_dbl >= w_n) ? W'(w_dbl - w_n) : w_dbl[W-1:0];
        w_sum  = {1'b0, w_red1} + {1'b0, w_opnd};
        if (r_r[r_step]) begin
            w_acc_next = (w_sum >= w_n) ? W'(w_sum - w_n) : w_sum[W-1:0];
        end else begin
            w_acc_next = w_red1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_state_next = c_DONE;
`ifdef RSA_MODEXP_SKIP_LEAD_EN
                    end else if (w_exp_zero) begin
                        w_state_next = c_DONE;
`endif
                    end else begin
                        w_state_next = c_SQR;
                    end
                end
            end
            c_SQR: begin
                if (w_last) begin
                    if (r_exp[r_bit]) begin
                        w_state_next = c_MUL;
                    end else if (r_bit == '0) begin
                        w_state_next = c_DONE;
                    end else begin
                        w_state_next = c_SQR;
                    end
                end
            end
            c_MUL: begin
                if (w_last) begin
                    w_state_next = (r_bit == '0) ? c_DONE : c_SQR;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (r_state == c_SQR) || (r_state == c_MUL);
        done    = (r_state == c_DONE);
        mux_sel = (r_state == c_MUL);
        err     = r_err;
        result  = r_result;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_exp    <= '0;
            r_modn   <= '0;
            r_r      <= '0;
            r_acc    <= '0;
            r_step   <= '0;
            r_bit    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_base <= base;
                        r_exp  <= exp;
                        r_modn <= modn;
                        r_err  <= w_bad;
                        r_r    <= W'(1);
                        r_acc  <= '0;
                        r_step <= c_TOP_IDX;
                        r_bit  <= w_start_bit;
                        if (w_bad) begin
                            r_result <= '0;
                        end else if (w_exp_zero) begin
                            // Only observable when the scan is skipped;
                            // otherwise the squaring path rewrites it.
                            r_result <= W'(1);
                        end
                    end
                end
                c_SQR, c_MUL: begin
                    if (w_last) begin
                        // R is committed only after all W steps, so the
                        // multiplier sees a stable operand throughout.
                        r_r    <= w_acc_next;
                        r_acc  <= '0;
                        r_step <= c_TOP_IDX;
                        if (w_state_next == c_DONE) begin
                            r_result <= w_acc_next;
                        end
                        if (w_state_next == c_SQR) begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end else begin
                        r_acc  <= w_acc_next;
                        r_step <= r_step - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

- Sequencing controller for RSA modular exponentiation: computes result = base^exp mod modn by left-to-right binary square-and-multiply.
- Contains an interleaved shift-add modular multiplier and a 2:1 operand select. The select chooses the current result (square) or the latched base (multiply) as the multiplier operand.
- Sits between the key/message registers and the encrypt/decrypt result register.

## Interface
Parameters
- W, 6, operand width for base, exp, modn and result.

Ports
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- base  in  W  message/ciphertext; must be < modn.
- exp  in  W  exponent (e or d).
- modn  in  W  modulus; must be ≥ 2.
- busy  out  1  high in SQR/MUL.
- done  out  1  single-cycle completion pulse.
- err  out  1  operand error flag; valid with done, held until next accepted start.
- result  out  W  exponentiation result; held until next accepted start.
- mux_sel  out  1  operand select: 0 = result (square), 1 = base (multiply); 0 outside MUL.

## Operation
States and transitions:
- IDLE
  - On start, latch base, exp and modn, and clear err.
  - If modn < 2 or base ≥ modn: set err=1, set result=0, go to DONE.
  - Otherwise: R=1, bit index i=W-1, go to SQR.
- SQR: R = R·R mod n, W cycles.
  - On the last step: if exp[i] go to MUL.
  - Else if i==0 go to DONE.
  - Else i--, stay in SQR.
- MUL: R = R·B mod n, W cycles, mux_sel=1.
  - On the last step: if i==0 go to DONE, else i-- and go to SQR.
- DONE: result=R (already written as 0 on the error path), done=1 for one cycle, then IDLE.

Modular multiply of a·b (both < n), one step per cycle, j from W-1 down to 0:
- acc = 2·acc; if acc ≥ n then acc -= n.
- If b[j]: acc = acc + a; if acc ≥ n then acc -= n.
- Intermediates are W+1 bits wide and never overflow.
- acc clears at the start of each multiply.

Boundary rules:
- start while busy or in DONE is ignored; latched operands do not change.
- Input changes after the sampling edge have no effect.
- exp=0 yields result 1.
- rst at any time: state=IDLE immediately. busy=0, done=0, err=0, result=0, mux_sel=0, internal R/acc/i cleared. Any in-flight operation is abandoned.

## Timing
- Reset values: every output is 0.
- Let k be the edge that samples start, and M = W·(W + popcount(exp)).
- Normal path: steps occupy edges k+1..k+M. done is high in the single cycle after edge k+M, and result is valid in that same cycle.
- Error path: done and err are high in the cycle after edge k.
- busy is high from after edge k through edge k+M, and is low in the done cycle.
- The next start is accepted on the edge after the done cycle (one cycle back-to-back gap).

## Configuration
- RSA_MODEXP_SKIP_LEAD_EN defined:
  - Starting index i = position of the highest set bit of exp, so leading zero bits are skipped.
  - M = W·(msb+1 + popcount(exp)).
  - exp=0 with valid operands goes IDLE→DONE with result=1; done follows edge k.
- Undefined: all W exponent bits are processed, and latency is fixed by popcount alone as above.

## Test plan
- W=6, base=4, exp=13, modn=33 → result=31, err=0.
  - Done 54 edges after start; 42 edges with the macro.
  - mux_sel=1 only during 18 MUL cycles.
- base=5, exp=0, modn=7 → result=1.
  - Done after 36 edges (macro: done after edge k).
- base=2, exp=63, modn=61 → result=8, 72-edge latency.
  - A second start pulsed mid-run is ignored and the result is unchanged.
- modn=1 (any base) → err=1, result=0, done after edge k.
  - base=9, modn=7 → err=1.
  - The next valid start (base=5, exp=3, modn=7) → result=6, err=0.
- Assert rst 20 cycles into the base=4, exp=13, modn=33 run:
  - All outputs go 0 asynchronously and no done occurs.
  - Restart after rst release → result=31.
- Back-to-back: start held high continuously → the second operation begins on the edge after the done cycle, and its done follows the first by M+2 edges.
